// File: rtl/redux_exec_ctrl_pkg.sv
// Shared definitions for the Redux run-control sequencer: FSM states and stop-cause codes.
package redux_exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_HOST      = 3'd1,
    CAUSE_STEP      = 3'd2,
    CAUSE_SELF_LOOP = 3'd3,
    CAUSE_BREAK     = 3'd4,
    CAUSE_LIMIT     = 3'd5
  } cause_t;

  // Causes that mark the program as finished; only reset leaves STOPPED.
  function automatic logic is_sticky(input cause_t cause);
    return (cause == CAUSE_SELF_LOOP) || (cause == CAUSE_LIMIT);
  endfunction

endpackage

// File: rtl/redux_exec_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module redux_exec_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/redux_exec_ctrl.sv
// Run-control sequencer for the Redux CPU: gates commits via cpu_en and records why execution stopped.
module redux_exec_ctrl
  import redux_exec_ctrl_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  cur_pc,
  input  logic [PC_W-1:0]  n_pc,
  output logic             cpu_en,
  output logic             busy,
  output logic             halted,
  output logic             stop_pulse,
  output logic [2:0]       stop_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_INSTR);
  localparam logic [CNT_W:0] ONE_W = (CNT_W+1)'(1);

  state_t state;
  cause_t cause;
  logic   self_loop;
  logic   limit_hit;
  logic   run_stop;
  cause_t run_cause;

  assign self_loop = (n_pc == cur_pc);
  // Compared one bit wider so a saturated count can never alias the limit.
  assign limit_hit = (MAX_INSTR != 0) && (({1'b0, instr_count} + ONE_W) == MAX_W);

  // Stop decision for an enabled RUN cycle, highest priority first.
  always_comb begin
    run_stop  = 1'b1;
    run_cause = CAUSE_NONE;
    if (self_loop) begin
      run_cause = CAUSE_SELF_LOOP;
    end else if (bp_en && (n_pc == bp_addr)) begin
      run_cause = CAUSE_BREAK;
    end else if (limit_hit) begin
      run_cause = CAUSE_LIMIT;
    end else if (halt_req) begin
      run_cause = CAUSE_HOST;
    end else begin
      run_stop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cause      <= CAUSE_NONE;
      stop_pulse <= 1'b0;
    end else begin
      stop_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start)     state <= ST_RUN;
          else if (step) state <= ST_STEP;
        end
        ST_RUN: begin
          if (run_stop) begin
            state      <= ST_STOPPED;
            cause      <= run_cause;
            stop_pulse <= 1'b1;
          end
        end
        ST_STEP: begin
          state      <= ST_STOPPED;
          cause      <= self_loop ? CAUSE_SELF_LOOP : CAUSE_STEP;
          stop_pulse <= 1'b1;
        end
        ST_STOPPED: begin
          if (!is_sticky(cause)) begin
            if (start)     state <= ST_RUN;
            else if (step) state <= ST_STEP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset suppresses commits in the reset cycle itself, even mid-run.
  assign busy       = (state == ST_RUN) || (state == ST_STEP);
  assign cpu_en     = busy && !rst;
  assign halted     = (state == ST_STOPPED);
  assign stop_cause = cause;

  redux_exec_ctrl_sat_counter #(.W(CNT_W)) u_instr_count (
    .clk   (clk),
    .rst   (rst),
    .en    (cpu_en),
    .count (instr_count)
  );

endmodule
